// File: rtl/auc4_pkg.sv
// Shared constants for the 4-bit ALU sequencer: widths, opcodes and FSM state encoding.
// Combinational definitions only, so there is no latency or backpressure here.
package auc4_pkg;
    localparam int W_DEFAULT   = 4;
    localparam int OPW_DEFAULT = 3;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_NOTA  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        HOLD    = 3'd4
    } state_t;
endpackage

// File: rtl/auc4_logic_unit.sv
// Gate-array slices plus adder: (a, b, opc) -> (y, carry), purely combinational.
// Zero latency, no handshake; carry is only meaningful for ADD/SUB.
module auc4_logic_unit
    import auc4_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int OPW = OPW_DEFAULT
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] opc,
    output logic [W-1:0]   y,
    output logic           carry
);
    logic [W:0] sum;

    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        case (opc)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[W-1:0];
                carry = sum[W];
            end
            // Two's-complement subtract; carry-out high means no borrow (a >= b).
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                y     = sum[W-1:0];
                carry = sum[W];
            end
            OP_NOTA:  y = ~a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/auc4_operand_sequencer.sv
// Collects A, B, opcode from one bus, executes, holds result on valid/ready.
// Result valid 2 edges after opcode accept; in_ready low while executing/holding until res_ready.
module auc4_operand_sequencer
    import auc4_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int OPW = OPW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] res_data,
    output logic         res_carry,
    output logic         res_zero,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy
);
    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [OPW-1:0] opc_q, opc_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_carry_q, res_carry_d;
    logic           res_zero_q, res_zero_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   lu_y;
    logic           lu_carry;
    logic           xfer_in, xfer_out;

    auc4_logic_unit #(.W(W), .OPW(OPW)) u_logic_unit (
        .a     (opa_q),
        .b     (opb_q),
        .opc   (opc_q),
        .y     (lu_y),
        .carry (lu_carry)
    );

    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
    assign busy      = (state_q != LOAD_A);
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign res_valid = res_valid_q;
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = res_valid_q & res_ready;

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opc_d       = opc_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        case (state_q)
            LOAD_A: if (xfer_in) begin
                opa_d   = in_data;
                state_d = LOAD_B;
            end
            LOAD_B: if (xfer_in) begin
                opb_d   = in_data;
                state_d = LOAD_OP;
            end
            LOAD_OP: if (xfer_in) begin
                opc_d   = in_data[OPW-1:0];
                state_d = EXEC;
            end
            EXEC: begin
                res_data_d  = lu_y;
                res_carry_d = lu_carry;
                res_zero_d  = (lu_y == '0);
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: if (xfer_out) begin
                res_valid_d = 1'b0;
                state_d     = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
        end
    end
endmodule

// File: tb/tb_auc4_operand_sequencer.sv
// Directed bench for auc4_operand_sequencer: literal per-test expectations plus a
// transaction-level model checked every cycle.
module tb_auc4_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_valid;
    logic       res_ready;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int m_checks = 0;
    int m_fails  = 0;

    always #5 clk = ~clk;

    auc4_operand_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Expected {zero, carry, result} from plain integer arithmetic.
    function automatic logic [5:0] exp_alu(input int a, input int b, input int op);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = 15 - (a | b);
            4: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            5: begin r = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
            6: r = 15 - a;
            default: r = b;
        endcase
        exp_alu = {(r == 0) ? 1'b1 : 1'b0, c[0], r[3:0]};
    endfunction

    // Transaction model: words gathered so far, a pending execute, a held result.
    bit        m_live = 0;
    int        m_words = 0;
    int        m_a = 0, m_b = 0;
    bit        m_exec = 0;
    bit        m_vld = 0;
    logic [5:0] m_pend = '0;
    logic [5:0] m_res = '0;

    task automatic mchk(input string name, input logic [3:0] act, input logic [3:0] exp);
        m_checks++;
        if (act !== exp) begin
            m_fails++;
            $display("FAIL model_%s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            mchk("in_ready", {3'b0, in_ready}, {3'b0, !m_exec && !m_vld});
            mchk("busy", {3'b0, busy}, {3'b0, (m_words != 0) || m_exec || m_vld});
            mchk("res_valid", {3'b0, res_valid}, {3'b0, m_vld});
            if (m_vld) begin
                mchk("res_data", res_data, m_res[3:0]);
                mchk("res_carry", {3'b0, res_carry}, {3'b0, m_res[4]});
                mchk("res_zero", {3'b0, res_zero}, {3'b0, m_res[5]});
            end
        end
        if (rst) begin
            m_live  = 1;
            m_words = 0;
            m_exec  = 0;
            m_vld   = 0;
        end else if (m_live) begin
            bit accept;
            accept = in_valid && !m_exec && !m_vld;
            if (m_vld && res_ready) m_vld = 0;
            if (m_exec) begin
                m_vld  = 1;
                m_exec = 0;
                m_res  = m_pend;
            end
            if (accept) begin
                case (m_words)
                    0: m_a = int'(in_data);
                    1: m_b = int'(in_data);
                    default: begin
                        m_pend = exp_alu(m_a, m_b, int'(in_data[2:0]));
                        m_exec = 1;
                    end
                endcase
                m_words = (m_words + 1) % 3;
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic send_word(input logic [3:0] w, input int bubbles);
        int n;
        repeat (bubbles) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("word_accept_timeout", {3'b0, in_ready}, 4'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Sends A, B, opcode; checks the 2-edge latency with junk on in_data meanwhile.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input int bubbles);
        send_word(a, bubbles);
        send_word(b, bubbles);
        send_word({1'b0, op}, bubbles);
        in_valid = 1'b1;
        in_data  = 4'hE;
        chk("exec_res_valid", {3'b0, res_valid}, 4'h0);
        chk("exec_in_ready", {3'b0, in_ready}, 4'h0);
        chk("exec_busy", {3'b0, busy}, 4'h1);
        @(posedge clk); #1;
        chk("lat_res_valid", {3'b0, res_valid}, 4'h1);
        in_valid = 1'b0;
    endtask

    task automatic take_result(input logic [3:0] r, input logic c, input logic z, input int stall);
        chk("res_data", res_data, r);
        chk("res_carry", {3'b0, res_carry}, {3'b0, c});
        chk("res_zero", {3'b0, res_zero}, {3'b0, z});
        repeat (stall) begin
            in_valid = ~in_valid;
            in_data  = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("hold_in_ready", {3'b0, in_ready}, 4'h0);
            chk("hold_res_valid", {3'b0, res_valid}, 4'h1);
            chk("hold_res_data", res_data, r);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_res_valid", {3'b0, res_valid}, 4'h0);
        chk("post_in_ready", {3'b0, in_ready}, 4'h1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", {3'b0, in_ready}, 4'h1);
        chk("rst_res_valid", {3'b0, res_valid}, 4'h0);
        chk("rst_busy", {3'b0, busy}, 4'h0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", {3'b0, in_ready}, 4'h1);
        chk("reset_res_valid", {3'b0, res_valid}, 4'h0);
        chk("reset_res_data", res_data, 4'h0);
        chk("reset_busy", {3'b0, busy}, 4'h0);
        chk("reset_res_carry", {3'b0, res_carry}, 4'h0);
        chk("reset_res_zero", {3'b0, res_zero}, 4'h0);

        // OR, back-to-back words
        run_op(4'b0101, 4'b0011, 3'b001, 0);
        take_result(4'b0111, 1'b0, 1'b0, 0);

        // ADD wrap with res_ready already high before res_valid
        res_ready = 1'b1;
        run_op(4'b1111, 4'b0001, 3'b100, 0);
        take_result(4'b0000, 1'b1, 1'b1, 0);

        // SUB with and without borrow
        run_op(4'b0010, 4'b0101, 3'b101, 0);
        take_result(4'b1101, 1'b0, 1'b0, 0);
        run_op(4'b0101, 4'b0101, 3'b101, 0);
        take_result(4'b0000, 1'b1, 1'b1, 0);

        // Bubbles between words and a 5-cycle stall in HOLD
        run_op(4'h9, 4'h6, 3'b100, 1);
        take_result(4'hF, 1'b0, 1'b0, 5);
        run_op(4'hC, 4'hA, 3'b010, 1);
        take_result(4'h6, 1'b0, 1'b0, 2);
        run_op(4'hC, 4'hA, 3'b000, 0);
        take_result(4'h8, 1'b0, 1'b0, 0);
        run_op(4'h3, 4'h5, 3'b110, 0);
        take_result(4'hC, 1'b0, 1'b0, 0);
        run_op(4'h3, 4'h9, 3'b111, 0);
        take_result(4'h9, 1'b0, 1'b0, 1);

        // Reset after A,B loaded, then reset while holding a result
        send_word(4'h1, 0);
        send_word(4'h2, 0);
        pulse_reset();
        run_op(4'h4, 4'h4, 3'b100, 0);
        chk("hold_before_rst", res_data, 4'h8);
        pulse_reset();
        run_op(4'h0, 4'h0, 3'b011, 0);
        take_result(4'hF, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        checks   = checks + m_checks;
        failures = failures + m_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
